univ_shift_register: RTL and testbench

- Parametrised-width universal register: the successor to the fixed-width enabled register.
- Adds load, logical shift in both directions, rotate and synchronous clear, selected by a mode input and gated by a synchronous enable.
- Tracks the number of shifts since the last load, so a serialiser/deserialiser upstream or downstream knows when the word has fully drained.
- Sits in datapaths as a parallel/serial conversion stage or a general-purpose state register.

---
 rtl/usr_pkg.sv | 29 ++
 rtl/usr_next_value.sv | 62 ++++++
 rtl/univ_shift_register.sv | 89 ++++++++
 tb/tb_univ_shift_register.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register.
//   usr_mode_t   : 3-bit operation select (HOLD/LOAD/SHL/SHR/ROTL/ROTR/CLEAR/RSVD)
//   USR_MODE_W   : width of the mode select
//   usr_sat_inc  : saturating increment used by the shift counter
// -----------------------------------------------------------------------------
package usr_pkg;

    localparam int USR_MODE_W = 3;

    typedef enum logic [USR_MODE_W-1:0] {
        HOLD  = 3'b000,
        LOAD  = 3'b001,
        SHL   = 3'b010,
        SHR   = 3'b011,
        ROTL  = 3'b100,
        ROTR  = 3'b101,
        CLEAR = 3'b110,
        RSVD  = 3'b111
    } usr_mode_t;

    // Counts up to limit and sticks there; the counter never wraps.
    function automatic int unsigned usr_sat_inc(input int unsigned cnt,
                                                input int unsigned limit);
        return (cnt < limit) ? cnt + 1 : limit;
    endfunction

endpackage

// File: rtl/usr_next_value.sv
// -----------------------------------------------------------------------------
// usr_next_value
// Purely combinational next-state logic for univ_shift_register.
// Ports:
//   q, shift_cnt   : current register contents and shift count
//   mode           : operation select (usr_mode_t encoding)
//   d              : parallel load data
//   sin_l, sin_r   : serial inputs (MSB side on SHR, LSB side on SHL)
//   q_next         : next register contents
//   cnt_next       : next shift count
// -----------------------------------------------------------------------------
module usr_next_value
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter int               CNT_W       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0]      q,
    input  logic [CNT_W-1:0]      shift_cnt,
    input  logic [USR_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]      d,
    input  logic                  sin_l,
    input  logic                  sin_r,
    output logic [WIDTH-1:0]      q_next,
    output logic [CNT_W-1:0]      cnt_next
);

    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = CNT_W'(usr_sat_inc(32'(shift_cnt), WIDTH));

    always_comb begin
        q_next   = q;
        cnt_next = shift_cnt;
        case (usr_mode_t'(mode))
            HOLD: ;
            LOAD: begin
                q_next   = d;
                cnt_next = '0;
            end
            SHL: begin
                q_next   = {q[WIDTH-2:0], sin_r};
                cnt_next = cnt_inc;
            end
            SHR: begin
                q_next   = {sin_l, q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            // Rotates lose no bits, so they do not count towards draining.
            ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            ROTR: q_next = {q[0], q[WIDTH-1:1]};
            CLEAR: begin
                q_next   = RESET_VALUE;
                cnt_next = '0;
            end
            RSVD: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_register.sv
// -----------------------------------------------------------------------------
// univ_shift_register
// Parametrised universal register: load, logical shift left/right, rotate,
// synchronous clear, with a saturating count of shifts since the last load.
// Optional build macro: USR_PARITY_EN adds a registered parity output.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   en         : synchronous enable; 0 holds all state
//   mode       : operation select (usr_mode_t), sampled when en=1
//   d          : parallel load data
//   sin_l      : serial in at MSB on shift-right
//   sin_r      : serial in at LSB on shift-left
//   q          : register contents
//   sout_l     : q[WIDTH-1]
//   sout_r     : q[0]
//   shift_cnt  : shifts since last LOAD/CLEAR/reset, saturating at WIDTH
//   parity     : XOR of q, registered with q (only with USR_PARITY_EN)
//   drained    : shift_cnt == WIDTH
// -----------------------------------------------------------------------------
module univ_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [USR_MODE_W-1:0]        mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
`ifdef USR_PARITY_EN
    output logic                         parity,
`endif
    output logic                         drained
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_next;

    usr_next_value #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .RESET_VALUE (RESET_VALUE)
    ) u_next (
        .q         (q),
        .shift_cnt (shift_cnt),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q_next    (q_next),
        .cnt_next  (cnt_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q         <= RESET_VALUE;
            shift_cnt <= '0;
        end else if (en) begin
            q         <= q_next;
            shift_cnt <= cnt_next;
        end
    end

`ifdef USR_PARITY_EN
    // Parity is taken from q_next so it lands on the same edge as q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity <= ^RESET_VALUE;
        end else if (en) begin
            parity <= ^q_next;
        end
    end
`endif

    assign sout_l  = q[WIDTH-1];
    assign sout_r  = q[0];
    assign drained = (shift_cnt == CNT_W'(WIDTH));

endmodule

// File: tb/tb_univ_shift_register.sv
module tb_univ_shift_register;
    import usr_pkg::*;

    localparam int W  = 7;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_l;
    logic          sin_r;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic [CW-1:0] shift_cnt;
    logic          drained;
`ifdef USR_PARITY_EN
    logic          parity;
`endif

    univ_shift_register #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
`ifdef USR_PARITY_EN
        .parity    (parity),
`endif
        .drained   (drained)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Compares every output against the expected register value and count.
    task automatic check_state(input string tag, input int eq, input int ecnt);
        chk({tag, ".q"},       64'(q),         64'(eq));
        chk({tag, ".cnt"},     64'(shift_cnt), 64'(ecnt));
        chk({tag, ".drained"}, 64'(drained),   64'(ecnt == W));
        chk({tag, ".sout_l"},  64'(sout_l),    64'((eq >> (W - 1)) & 1));
        chk({tag, ".sout_r"},  64'(sout_r),    64'(eq & 1));
`ifdef USR_PARITY_EN
        chk({tag, ".parity"},  64'(parity),    64'($countones(eq) % 2));
`endif
    endtask

    task automatic apply(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                         input logic sl, input logic sr);
        en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         sl;
        logic         sr;
        int           eq;
        int           ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic [2:0] m, input int dd,
                                input logic sl, input logic sr, input int eq, input int ecnt);
        vec_t v;
        v.en = e; v.mode = m; v.d = W'(dd); v.sl = sl; v.sr = sr;
        v.eq = eq; v.ecnt = ecnt;
        return v;
    endfunction

    // Reference model: shifts and rotates as integer arithmetic on 0..2^W-1.
    int m_q;
    int m_cnt;

    task automatic model_step(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                              input logic sl, input logic sr);
        int full;
        int top;
        full = 1 << W;
        top  = 1 << (W - 1);
        if (!e) return;
        case (m)
            3'd1: begin m_q = int'(dd); m_cnt = 0; end
            3'd2: begin m_q = (m_q * 2 + int'(sr)) % full; m_cnt = (m_cnt < W) ? m_cnt + 1 : W; end
            3'd3: begin m_q = m_q / 2 + int'(sl) * top;    m_cnt = (m_cnt < W) ? m_cnt + 1 : W; end
            3'd4: m_q = (m_q * 2) % full + m_q / top;
            3'd5: m_q = m_q / 2 + (m_q % 2) * top;
            3'd6: begin m_q = 0; m_cnt = 0; end
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("por", 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Async reset mid-cycle after a load.
        apply(1'b1, LOAD, 7'h55, 1'b0, 1'b0);
        check_state("pre_rst", 'h55, 0);
        #2 reset = 1'b0;
        #1 check_state("async_rst", 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, LOAD, 7'h7F, 1'b1, 1'b1);
            check_state($sformatf("rst_hold%0d", i), 0, 0);
        end

        // Directed vectors, starting from q=0 cnt=0.
        vecs.push_back(mk(1, LOAD,  'h55, 0, 0, 'h55, 0));
        vecs.push_back(mk(0, LOAD,  'h12, 0, 0, 'h55, 0));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h2B, 1));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h57, 2));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h2F, 3));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h5F, 4));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h3F, 5));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h7F, 6));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h7F, 7));
        vecs.push_back(mk(1, SHL,   0,    0, 1, 'h7F, 7));
        vecs.push_back(mk(1, ROTL,  0,    0, 0, 'h7F, 7));
        vecs.push_back(mk(1, LOAD,  'h40, 0, 0, 'h40, 0));
        vecs.push_back(mk(1, SHR,   0,    0, 1, 'h20, 1));
        vecs.push_back(mk(1, SHR,   0,    0, 1, 'h10, 2));
        vecs.push_back(mk(1, SHR,   0,    1, 0, 'h48, 3));
        vecs.push_back(mk(1, LOAD,  'h01, 0, 0, 'h01, 0));
        vecs.push_back(mk(1, ROTR,  0,    1, 1, 'h40, 0));
        vecs.push_back(mk(1, ROTL,  0,    0, 0, 'h01, 0));
        vecs.push_back(mk(1, RSVD,  'h7F, 1, 1, 'h01, 0));
        vecs.push_back(mk(1, SHL,   0,    0, 0, 'h02, 1));
        vecs.push_back(mk(1, ROTR,  0,    0, 0, 'h01, 1));
        vecs.push_back(mk(1, LOAD,  'h33, 0, 0, 'h33, 0));
        vecs.push_back(mk(1, SHL,   0,    0, 0, 'h66, 1));
        vecs.push_back(mk(1, CLEAR, 'h7F, 1, 1, 'h00, 0));
        vecs.push_back(mk(1, HOLD,  'h7F, 1, 1, 'h00, 0));
        vecs.push_back(mk(1, LOAD,  'h07, 0, 0, 'h07, 0));
        vecs.push_back(mk(1, SHL,   0,    0, 0, 'h0E, 1));
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
            check_state($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ecnt);
        end

        // Randomised run against the model; shifts are favoured so the
        // counter reaches saturation regularly.
        m_q   = 'h0E;
        m_cnt = 1;
        for (int i = 0; i < 3000; i++) begin
            logic         e;
            logic [2:0]   m;
            logic [W-1:0] dd;
            logic         sl;
            logic         sr;
            e  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) m = 3'($urandom_range(0, 7));
            else                           m = 3'($urandom_range(2, 5));
            dd = W'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            model_step(e, m, dd, sl, sr);
            apply(e, m, dd, sl, sr);
            check_state($sformatf("rnd%0d", i), m_q, m_cnt);
            if (i == 1500) begin
                #2 reset = 1'b0;
                #1;
                m_q = 0; m_cnt = 0;
                check_state("rnd_rst", 0, 0);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
